// File: rtl/fetch_pc_ctrl.sv
// IF-stage program-counter controller for the 16-bit pipelined MIPS.
// It owns the PC register and the instruction-memory fetch handshake, and it
// applies branch/jump redirects that were resolved in ID. A redirect that
// cannot take effect in the cycle it is requested is held until the fetch
// can advance. The wrong-path IF/ID entry is flushed when a redirect is
// applied, and applied redirects are counted with a saturating counter.
module fetch_pc_ctrl #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_INC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              if_id_flush,
  output logic              redirect_pending,
  output logic [15:0]       taken_cnt
);

  typedef enum logic [1:0] {
    S_BOOT       = 2'd0,
    S_RUN        = 2'd1,
    S_REDIR_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_target;
  logic [15:0]       r_taken_cnt;

  logic              w_imem_req;
  logic              w_adv;
  logic              w_apply;
  logic              w_capture;
  logic              w_seq_step;
  logic [ADDR_W-1:0] w_pc_inc;

  // Fetch advances only when a request is out, memory accepts it and the
  // hazard unit is not freezing IF/ID.
  assign w_adv    = w_imem_req & imem_ready & ~stall;
  assign w_pc_inc = r_pc + ADDR_W'(PC_INC);

  // State register; rst has priority over every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: BOOT lasts one cycle; a blocked redirect parks in
  // REDIR_WAIT until the fetch can advance.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_state_next = r_state;
    unique case (r_state)
      S_BOOT:       w_state_next = S_RUN;
      S_RUN:        if (br_cond && !w_adv) w_state_next = S_REDIR_WAIT;
      S_REDIR_WAIT: if (w_adv) w_state_next = S_RUN;
      default:      w_state_next = S_BOOT;
    endcase
  end

  // Output/control decode from the current state and handshake.
  always_comb begin
    w_imem_req = 1'b0;
    w_apply    = 1'b0;
    w_capture  = 1'b0;
    w_seq_step = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_imem_req = 1'b0;
      end
      S_RUN: begin
        w_imem_req = 1'b1;
        w_apply    = br_cond & w_adv;
        w_capture  = br_cond & ~w_adv;
        w_seq_step = ~br_cond & w_adv;
      end
      S_REDIR_WAIT: begin
        // br_cond/br_target are ignored here: the same branch is still in ID.
        w_imem_req = 1'b1;
        w_apply    = w_adv;
      end
      default: begin
        w_imem_req = 1'b0;
      end
    endcase
  end

  // PC, pending target and taken counter updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_pend_target <= '0;
      r_taken_cnt   <= '0;
    end else begin
      if (w_apply) begin
        r_pc <= (r_state == S_REDIR_WAIT) ? r_pend_target : br_target;
      end else if (w_seq_step) begin
        r_pc <= w_pc_inc;
      end
      if (w_capture) begin
        r_pend_target <= br_target;
      end
      if (w_apply && (r_taken_cnt != 16'hFFFF)) begin
        r_taken_cnt <= r_taken_cnt + 16'd1;
      end
    end
  end

  assign imem_req         = w_imem_req;
  assign pc               = r_pc;
  assign pc_next_seq      = w_pc_inc;
  // Reset wins over a redirect that would otherwise apply in the same cycle.
  assign if_id_flush      = w_apply & ~rst;
  assign redirect_pending = (r_state == S_REDIR_WAIT);
  assign taken_cnt        = r_taken_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl. Expected output values are queued when
// each cycle's inputs are driven and compared shortly afterwards, well
// before the next rising edge.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_cond;
  logic [15:0] br_target;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  logic        if_id_flush;
  logic        redirect_pending;
  logic [15:0] taken_cnt;

  int total = 0;
  int bad   = 0;

  typedef enum int {O_REQ, O_PC, O_NSEQ, O_FLUSH, O_PEND, O_CNT} sig_e;
  typedef struct {
    string       tag;
    sig_e        sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  fetch_pc_ctrl #(
    .ADDR_W  (16),
    .RESET_PC(16'h0000),
    .PC_INC  (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .br_cond         (br_cond),
    .br_target       (br_target),
    .stall           (stall),
    .imem_ready      (imem_ready),
    .imem_req        (imem_req),
    .pc              (pc),
    .pc_next_seq     (pc_next_seq),
    .if_id_flush     (if_id_flush),
    .redirect_pending(redirect_pending),
    .taken_cnt       (taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input sig_e s);
    case (s)
      O_REQ:   return {15'd0, imem_req};
      O_PC:    return pc;
      O_NSEQ:  return pc_next_seq;
      O_FLUSH: return {15'd0, if_id_flush};
      O_PEND:  return {15'd0, redirect_pending};
      default: return taken_cnt;
    endcase
  endfunction

  // Drive one cycle's inputs on the falling edge.
  task automatic drive(input logic r, input logic bc, input logic [15:0] bt,
                       input logic st, input logic rdy);
    @(negedge clk);
    rst        = r;
    br_cond    = bc;
    br_target  = bt;
    stall      = st;
    imem_ready = rdy;
  endtask

  task automatic expect_val(input string tag, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic check_out();
    exp_t e;
    logic [15:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      total++;
      assert (o === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; br_cond = 1'b0; br_target = 16'h0; stall = 1'b0; imem_ready = 1'b1;

    // Reset for two cycles, then one BOOT cycle with no fetch.
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    expect_val("boot_req", O_REQ, 16'd0);
    expect_val("boot_pc", O_PC, 16'h0000);
    expect_val("boot_flush", O_FLUSH, 16'd0);
    expect_val("boot_pend", O_PEND, 16'd0);
    expect_val("boot_cnt", O_CNT, 16'd0);
    check_out();

    // Free run: pc steps 0..4.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      expect_val("run_req", O_REQ, 16'd1);
      expect_val("run_pc", O_PC, 16'(i));
      expect_val("run_nseq", O_NSEQ, 16'(i + 1));
      expect_val("run_flush", O_FLUSH, 16'd0);
      check_out();
    end

    // Immediate redirect at pc=5.
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
    expect_val("imm_pc", O_PC, 16'h0005);
    expect_val("imm_flush", O_FLUSH, 16'd1);
    check_out();
    // Second immediate redirect, to pc=7.
    drive(1'b0, 1'b1, 16'h0007, 1'b0, 1'b1);
    expect_val("imm_tgt", O_PC, 16'h0040);
    expect_val("imm_cnt", O_CNT, 16'd1);
    expect_val("imm2_flush", O_FLUSH, 16'd1);
    check_out();

    // Blocked redirect: stall for three cycles at pc=7.
    drive(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1);
    expect_val("blk_pc0", O_PC, 16'h0007);
    expect_val("blk_cnt", O_CNT, 16'd2);
    expect_val("blk_flush0", O_FLUSH, 16'd0);
    expect_val("blk_pend0", O_PEND, 16'd0);
    check_out();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1);
      expect_val("blk_pend", O_PEND, 16'd1);
      expect_val("blk_pc", O_PC, 16'h0007);
      expect_val("blk_flush", O_FLUSH, 16'd0);
      check_out();
    end
    drive(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
    expect_val("blk_rel_flush", O_FLUSH, 16'd1);
    expect_val("blk_rel_pc", O_PC, 16'h0007);
    expect_val("blk_rel_pend", O_PEND, 16'd1);
    check_out();

    // Pending ignores a newer target while imem is not ready.
    drive(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
    expect_val("blk_tgt", O_PC, 16'h0100);
    expect_val("blk_cnt3", O_CNT, 16'd3);
    expect_val("blk_done_pend", O_PEND, 16'd0);
    expect_val("cap_flush", O_FLUSH, 16'd0);
    check_out();
    drive(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    expect_val("ign_pend", O_PEND, 16'd1);
    expect_val("ign_req", O_REQ, 16'd1);
    expect_val("ign_flush", O_FLUSH, 16'd0);
    expect_val("ign_pc", O_PC, 16'h0100);
    check_out();
    drive(1'b0, 1'b1, 16'h0200, 1'b0, 1'b1);
    expect_val("ign_rel_flush", O_FLUSH, 16'd1);
    check_out();
    drive(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
    expect_val("ign_tgt", O_PC, 16'h0300);
    expect_val("ign_cnt", O_CNT, 16'd4);
    expect_val("ign_pend_clr", O_PEND, 16'd0);
    check_out();

    // Wrap-around of pc and pc_next_seq.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    expect_val("wrap_pc0", O_PC, 16'hFFFE);
    expect_val("wrap_nseq0", O_NSEQ, 16'hFFFF);
    expect_val("wrap_cnt", O_CNT, 16'd5);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    expect_val("wrap_pc1", O_PC, 16'hFFFF);
    expect_val("wrap_nseq1", O_NSEQ, 16'h0000);
    check_out();
    // Redirect to the current pc still counts as a redirect.
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    expect_val("wrap_pc2", O_PC, 16'h0000);
    expect_val("self_flush", O_FLUSH, 16'd1);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    expect_val("self_pc", O_PC, 16'h0000);
    expect_val("self_cnt", O_CNT, 16'd6);
    expect_val("stall_flush", O_FLUSH, 16'd0);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    expect_val("nrdy_pc", O_PC, 16'h0000);
    check_out();

    // Back-to-back redirects bring taken_cnt to 16'hFFFE.
    for (int i = 0; i < 65528; i++) begin
      drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    expect_val("sat_pre", O_CNT, 16'hFFFE);
    expect_val("burst_pc", O_PC, 16'h0010);
    check_out();
    drive(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1);
    expect_val("sat_flush0", O_FLUSH, 16'd1);
    check_out();
    drive(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1);
    expect_val("sat_max", O_CNT, 16'hFFFF);
    expect_val("sat_pc", O_PC, 16'h0020);
    expect_val("sat_flush1", O_FLUSH, 16'd1);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    expect_val("sat_hold", O_CNT, 16'hFFFF);
    expect_val("sat_pc2", O_PC, 16'h0030);
    check_out();

    // Reset while a redirect is pending.
    drive(1'b0, 1'b1, 16'h0055, 1'b1, 1'b1);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    expect_val("rp_pend", O_PEND, 16'd1);
    expect_val("rp_pc", O_PC, 16'h0030);
    check_out();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    expect_val("rp_rst_pc", O_PC, 16'h0000);
    expect_val("rp_rst_pend", O_PEND, 16'd0);
    expect_val("rp_rst_req", O_REQ, 16'd0);
    expect_val("rp_rst_cnt", O_CNT, 16'd0);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    expect_val("rp_run_req", O_REQ, 16'd1);
    expect_val("rp_run_pc0", O_PC, 16'h0000);
    check_out();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    expect_val("rp_run_pc1", O_PC, 16'h0001);
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
